// File: rtl/pdm_pkg.sv
// Shared constants and width helpers for the PDM modulator and its delta-sigma core.
package pdm_pkg;

    localparam int DATA_W = 16;
    localparam int OSR    = 64;
    localparam int ACC_W  = DATA_W + 4;
    localparam int FS     = 2 ** (DATA_W - 1);
    localparam int CLAMP  = (3 * FS) / 4;

    function automatic int acc_w_for(input int dw);
        return dw + 4;
    endfunction

    // 0.75 of full scale keeps the second-order loop well inside its stable input range
    function automatic int clamp_for(input int dw);
        return (3 * (1 << (dw - 1))) / 4;
    endfunction

endpackage

// File: rtl/pdm_sd2_core.sv
// Second-order delta-sigma loop: two saturating integrators and a sign quantizer.
module pdm_sd2_core
    import pdm_pkg::*;
#(
    parameter int DATA_W = pdm_pkg::DATA_W,
    parameter int ACC_W  = pdm_pkg::ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic signed [DATA_W-1:0] x,
    output logic                     pdm_bit
);

    localparam int EXT_W = ACC_W + 2;
    localparam logic signed [EXT_W-1:0] FS_E  = {{(EXT_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] MAX_E = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_E = {3'b111, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] i1, i2, i1_next, i2_next;
    logic signed [EXT_W-1:0] fb, x_ext, i1_ext, i2_ext, i1n_ext;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [EXT_W-1:0] v);
        if (v > MAX_E)
            return MAX_E[ACC_W-1:0];
        else if (v < MIN_E)
            return MIN_E[ACC_W-1:0];
        else
            return v[ACC_W-1:0];
    endfunction

    always_comb begin
        fb      = pdm_bit ? FS_E : -FS_E;
        x_ext   = {{(EXT_W-DATA_W){x[DATA_W-1]}}, x};
        i1_ext  = {{2{i1[ACC_W-1]}}, i1};
        i2_ext  = {{2{i2[ACC_W-1]}}, i2};
        i1_next = sat(i1_ext + x_ext - fb);
        // second stage integrates the freshly updated first stage
        i1n_ext = {{2{i1_next[ACC_W-1]}}, i1_next};
        i2_next = sat(i2_ext + i1n_ext - fb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1      <= '0;
            i2      <= '0;
            pdm_bit <= 1'b0;
        end else if (tick) begin
            i1      <= i1_next;
            i2      <= i2_next;
            pdm_bit <= !i2_next[ACC_W-1];
        end
    end

endmodule

// File: rtl/pdm_modulator.sv
// PCM-to-PDM modulator: single-slot sample buffer, bit-rate divider, frame counter
// and a second-order delta-sigma core fed with the clamped active sample.
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int DATA_W  = pdm_pkg::DATA_W,
    parameter int OSR     = pdm_pkg::OSR,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              pdm_out,
    output logic              pdm_tick,
    output logic              frame_start,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam int ACC_BITS = acc_w_for(DATA_W);
    localparam int CNT_W    = $clog2(OSR);
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic signed [DATA_W-1:0] CLAMP_P = DATA_W'(clamp_for(DATA_W));

    logic signed [DATA_W-1:0] pend_data, act_data, x_sel, x_clamped;
    logic                     pend_full;
    logic [CNT_W-1:0]         bit_cnt;
    logic [DIV_W-1:0]         div_cnt;
    logic                     tick, boundary, accept;

    assign tick     = en && (div_cnt == '0);
    assign boundary = tick && (bit_cnt == '0);
    assign s_ready  = !pend_full;
    assign accept   = s_valid && s_ready;

    // the boundary tick already modulates the sample being promoted this cycle
    always_comb begin
        x_sel = (boundary && pend_full) ? pend_data : act_data;
        if (x_sel > CLAMP_P)
            x_clamped = CLAMP_P;
        else if (x_sel < -CLAMP_P)
            x_clamped = -CLAMP_P;
        else
            x_clamped = x_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            bit_cnt     <= '0;
            pend_data   <= '0;
            pend_full   <= 1'b0;
            act_data    <= '0;
            underrun    <= 1'b0;
            pdm_tick    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (en)
                div_cnt <= (div_cnt == '0) ? DIV_W'(CLK_DIV - 1) : div_cnt - 1'b1;
            if (tick)
                bit_cnt <= (bit_cnt == CNT_W'(OSR - 1)) ? '0 : bit_cnt + 1'b1;
            if (boundary && pend_full)
                act_data <= pend_data;
            if (accept) begin
                pend_data <= s_data;
                pend_full <= 1'b1;
            end else if (boundary) begin
                pend_full <= 1'b0;
            end
            // a fresh underrun wins over a simultaneous clear
            if (boundary && !pend_full)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
            pdm_tick    <= tick;
            frame_start <= boundary;
        end
    end

    pdm_sd2_core #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_BITS)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .x       (x_clamped),
        .pdm_bit (pdm_out)
    );

endmodule

// File: tb/tb_pdm_modulator.sv
// Scoreboard bench: expected 64-bit frames come from an integer model of the loop equations.
module tb_pdm_modulator;

    localparam int OSR     = 64;
    localparam int FS      = 32768;
    localparam int CLAMP   = 24576;
    localparam int ACC_MAX = (1 << 19) - 1;
    localparam int ACC_MIN = -(1 << 19);

    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, s_valid = 1'b0, underrun_clr = 1'b0;
    logic [15:0] s_data = '0;
    logic s_ready, pdm_out, pdm_tick, frame_start, underrun;

    logic en4 = 1'b1, s_valid4 = 1'b0, clr4 = 1'b0;
    logic [15:0] s_data4 = '0;
    logic s_ready4, pdm_out4, pdm_tick4, frame_start4, underrun4;

    pdm_modulator #(.DATA_W(16), .OSR(64), .CLK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .pdm_out(pdm_out), .pdm_tick(pdm_tick),
        .frame_start(frame_start), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    pdm_modulator #(.DATA_W(16), .OSR(64), .CLK_DIV(4)) dut_div4 (
        .clk(clk), .rst_n(rst_n), .en(en4), .s_data(s_data4), .s_valid(s_valid4),
        .s_ready(s_ready4), .pdm_out(pdm_out4), .pdm_tick(pdm_tick4),
        .frame_start(frame_start4), .underrun(underrun4), .underrun_clr(clr4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bits;
        bit          dens;
        int          lo;
        int          hi;
    } frame_t;

    frame_t exp_q[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int m_i1 = 0, m_i2 = 0;
    bit m_bit = 1'b0;
    bit mon_on = 1'b0, tick_watch = 1'b0, en_prev = 1'b0, have_last = 1'b0;
    int tick_miss = 0, tick_seen = 0, last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int sat_acc(input int v);
        return (v > ACC_MAX) ? ACC_MAX : (v < ACC_MIN) ? ACC_MIN : v;
    endfunction

    // one whole frame of the reference loop for a (possibly repeated) sample
    function automatic void model_push(input int x, input bit dens, input int lo, input int hi);
        frame_t f;
        int xc, fb;
        xc = (x > CLAMP) ? CLAMP : (x < -CLAMP) ? -CLAMP : x;
        f.bits = '0;
        for (int k = 0; k < OSR; k++) begin
            fb = m_bit ? FS : -FS;
            m_i1 = sat_acc(m_i1 + xc - fb);
            m_i2 = sat_acc(m_i2 + m_i1 - fb);
            m_bit = (m_i2 >= 0);
            f.bits[k] = m_bit;
        end
        f.dens = dens;
        f.lo = lo;
        f.hi = hi;
        exp_q.push_back(f);
    endfunction

    // monitor: collects bits on pdm_tick, pops and compares each completed frame
    initial begin
        logic [63:0] cur;
        frame_t f;
        int nb;
        nb = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (tick_watch && en_prev && en) begin
                tick_seen++;
                if (!pdm_tick) tick_miss++;
            end
            en_prev = en;
            if (!mon_on) begin
                nb = 0;
            end else if (pdm_tick) begin
                if (frame_start && nb != 0) begin
                    check("frame_align", nb, 0);
                    nb = 0;
                end
                cur[nb] = pdm_out;
                nb++;
                if (nb == OSR) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", 1, 0);
                    end else begin
                        f = exp_q.pop_front();
                        check("frame_bits", longint'(cur), longint'(f.bits));
                        if (f.dens) check_range("frame_density", $countones(cur), f.lo, f.hi);
                    end
                end
            end
        end
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic offer(input int x, input int gap, input bit chk_int,
                         input bit dens, input int lo, input int hi);
        int n;
        if (gap > 0) begin
            s_valid = 1'b0;
            n = 0;
            while (!s_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        s_data = 16'(x);
        s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check("accept_timeout", n, 0);
        end else begin
            if (chk_int && have_last) check("accept_interval", cyc - last_acc, OSR);
            last_acc = cyc;
            have_last = 1'b1;
            model_push(x, dens, lo, hi);
        end
        @(posedge clk); #1;
        check("ready_low_after_accept", s_ready, 0);
    endtask

    task automatic wait_fs(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        ok = frame_start;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[4];
        int los[4];
        int his[4];
        int idx, n, cnt;
        bit ok;
        logic [15:0] r;
        vals = '{0, 16384, -16384, 32767};
        los  = '{31, 46, 14, 54};
        his  = '{33, 50, 18, 58};

        #2 rst_n = 1'b0;
        #10;
        check("rst_s_ready", s_ready, 1);
        check("rst_pdm_out", pdm_out, 0);
        check("rst_pdm_tick", pdm_tick, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_on = 1'b1;

        // directed densities with s_valid held high throughout
        idx = 0;
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 7; k++) begin
                offer(vals[v], 0, idx >= 2, k >= 4, los[v], his[v]);
                if (idx == 0) begin
                    en = 1'b1;
                    tick_watch = 1'b1;
                end
                idx++;
            end
        end
        tick_watch = 1'b0;
        check("tick_every_clk_miss", tick_miss, 0);
        check("tick_every_clk_seen", tick_seen > 1000, 1);

        // starve the slot: last sample repeats and underrun rises at the following boundary
        s_valid = 1'b0;
        model_push(32767, 1'b1, 54, 58);
        wait_fs(ok);
        check("fs_seen_1", ok, 1);
        check("underrun_before", underrun, 0);
        wait_fs(ok);
        check("fs_seen_2", ok, 1);
        check("underrun_at_boundary", underrun, 1);
        @(posedge clk); #1;
        underrun_clr = 1'b1;
        @(posedge clk); #1;
        underrun_clr = 1'b0;
        check("underrun_cleared", underrun, 0);
        drain();
        mon_on = 1'b0;

        // random samples with random offer delays after each boundary
        en = 1'b0;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        m_i1 = 0;
        m_i2 = 0;
        m_bit = 1'b0;
        exp_q.delete();
        have_last = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_on = 1'b1;
        for (int k = 0; k < 14; k++) begin
            r = 16'($urandom());
            if (k == 3) r = 16'h8000;
            offer(int'($signed(r)), (k == 0) ? 1 : int'($urandom_range(1, 40)), 1'b0, 1'b0, 0, 0);
            if (k == 0) en = 1'b1;
        end
        check("no_underrun_random", underrun, 0);
        drain();
        mon_on = 1'b0;

        // asynchronous reset at bit 30 of a frame
        wait_fs(ok);
        check("fs_before_reset", ok, 1);
        n = 0;
        cnt = 0;
        while (n < 30 && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (pdm_tick) n++;
        end
        check("reached_bit30", n, 30);
        rst_n = 1'b0;
        #1;
        check("midrst_pdm_out", pdm_out, 0);
        check("midrst_pdm_tick", pdm_tick, 0);
        check("midrst_frame_start", frame_start, 0);
        check("midrst_underrun", underrun, 0);
        check("midrst_s_ready", s_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pdm_tick && n < 10);
        check("post_rst_tick_seen", pdm_tick, 1);
        check("post_rst_frame_start", frame_start, 1);

        // divided bit clock
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pdm_tick4 && n < 20);
        check("div4_tick_seen", pdm_tick4, 1);
        for (int k = 0; k < 5; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!pdm_tick4 && cnt < 20);
            check("div4_interval", cnt, 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_modulator.md
PDM_MODULATOR -- requirements
Module: pdm_modulator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, PCM sample width (signed two's complement).
REQ-002 SHALL have parameter OSR, default 64, PDM bits emitted per PCM sample (equal to the receive-chain decimation 8*2*2*2).
REQ-003 SHALL have parameter CLK_DIV, default 1, clk cycles per PDM bit (1 = one bit every clk).
REQ-004 SHALL have port clk, input, 1, single clock for all logic; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, run enable; low freezes divider, counters and integrators.
REQ-007 SHALL have port s_data, input, DATA_W, PCM sample.
REQ-008 SHALL have port s_valid, input, 1, sample offered.
REQ-009 SHALL have port s_ready, output, 1, pending slot empty.
REQ-010 SHALL have port pdm_out, output, 1, PDM bitstream.
REQ-011 SHALL have port pdm_tick, output, 1, one-clk pulse in the cycle pdm_out changes to a new bit.
REQ-012 SHALL have port frame_start, output, 1, one-clk pulse coincident with pdm_tick for bit 0 of each sample frame.
REQ-013 SHALL have port underrun, output, 1, sticky flag, no sample pending at frame boundary.
REQ-014 SHALL have port underrun_clr, input, 1, synchronous clear of underrun.

Function
REQ-015 SHALL transfer a sample when s_valid && s_ready on a rising clk edge; s_ready = pending slot empty, combinationally independent of s_valid.
REQ-016 SHALL generate an internal tick every CLK_DIV clk cycles while en=1; the bit counter (0..OSR-1) advances on each tick and wraps OSR-1 -> 0.
REQ-017 SHALL, on a tick with bit counter = 0, move the pending sample into the active register and empty the slot; a sample accepted in that same cycle stays pending until the next boundary.
REQ-018 SHALL, at a boundary with the slot empty, keep the previous active sample and set underrun; underrun_clr and a simultaneous new underrun -> underrun stays 1.
REQ-019 SHALL clamp the active sample to +/-CLAMP (0.75 full scale; 24576 for DATA_W=16) before modulation.
REQ-020 SHALL implement a second-order modulator per tick: fb = pdm_out ? +FS : -FS (FS = 2^(DATA_W-1)); i1' = i1 + x - fb; i2' = i2 + i1' - fb; pdm_out <= (i2' >= 0).
REQ-021 SHALL hold i1, i2 at ACC_W = DATA_W+4 bits signed and saturate each at the ACC_W limits, never wrapping.
REQ-022 SHALL register pdm_out; pdm_tick and frame_start assert in the clk cycle following the tick edge that updates pdm_out.
REQ-023 SHALL produce its first modulated bit of sample N at the frame boundary after acceptance: latency 1 to OSR*CLK_DIV+1 clk cycles.
REQ-024 SHALL, with en=0, hold pdm_out, all counters and integrators, and keep accepting into the pending slot.

Reset
REQ-025 SHALL on rst_n=0 clear asynchronously: pending slot empty (s_ready=1), active sample 0, i1=i2=0, bit counter 0, divider 0, pdm_out=0, pdm_tick=0, frame_start=0, underrun=0.
REQ-026 SHALL, on reset mid-frame, discard pending and active samples; the first post-reset tick is a frame boundary.

Structure
REQ-027 SHALL place DATA_W, OSR, ACC_W, FS and CLAMP constants in the shared package pdm_pkg.
REQ-028 SHALL place the integrator arithmetic and saturation in one sub-module pdm_sd2_core (inputs x, tick; output bit).

Verification
REQ-029 SHALL check: reset, en=1, s_data=0 every frame -> 32+/-1 ones per 64-bit frame after 4 settling frames, pdm_tick every clk.
REQ-030 SHALL check: s_data=16384 -> 48+/-2 ones per frame; s_data=-16384 -> 16+/-2.
REQ-031 SHALL check: s_data=32767 -> clamped to 24576, 56+/-2 ones per frame, no integrator wrap (density stays monotonic).
REQ-032 SHALL check: s_valid held high -> exactly one acceptance per 64 clks, s_ready low between acceptance and next boundary; no samples lost or duplicated.
REQ-033 SHALL check: stop offering samples -> underrun=1 at next frame_start, last sample repeated; underrun_clr -> 0 on the next clk.
REQ-034 SHALL check: rst_n low at bit 30 of a frame -> all outputs 0 within the same cycle, first post-reset tick asserts frame_start; CLK_DIV=4 -> pdm_tick every 4 clks.
